// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C burst master.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP
  } i2c_state_t;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timebase: a CLK_DIV prescaler feeding a 2-bit quarter counter.
module i2c_phase_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  logic [7:0] div_q;
  logic [1:0] phase_q;

  // tick marks the last clk cycle of the current quarter
  assign tick_o  = en_i && (div_q == 8'(CLK_DIV - 1));
  assign phase_o = phase_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      div_q   <= 8'd0;
      phase_q <= 2'd0;
    end else if (en_i) begin
      if (tick_o) begin
        div_q   <= 8'd0;
        phase_q <= phase_q + 2'd1;
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_burst_master.sv
// Single-master I2C burst engine: START, address, N write or read bytes, STOP.
module i2c_burst_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             scl_out,
  output logic             sda_out,
  input  logic             sda_in
);

  i2c_state_t       state_q;
  logic             scl_q, sda_q;
  logic [7:0]       sh_q;
  logic [2:0]       bit_q;
  logic [LEN_W-1:0] cnt_q;
  logic [6:0]       addr_q;
  logic             rw_q, ack_q, stall_q;
  logic             busy_q, done_q, cmd_ready_q, wr_ready_q, rd_valid_q, nack_q;
  logic [7:0]       rd_data_q;

  logic             tick;
  logic [1:0]       phase;
  logic             accept;
  logic [LEN_W-1:0] cnt_d;
  logic [7:0]       sh_rx_d;

  assign accept  = cmd_valid && cmd_ready_q;
  assign cnt_d   = cnt_q - LEN_W'(1);
  assign sh_rx_d = {sh_q[6:0], sda_in};

  // the timebase freezes in Q0 while waiting for write data
  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en_i    (busy_q && !stall_q),
    .clr_i   (accept),
    .tick_o  (tick),
    .phase_o (phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      sh_q        <= 8'd0;
      bit_q       <= 3'd0;
      cnt_q       <= '0;
      addr_q      <= 7'd0;
      rw_q        <= I2C_WRITE;
      ack_q       <= ACK;
      stall_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      nack_q      <= 1'b0;
      rd_data_q   <= 8'd0;
    end else begin
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;

      // common bit clocking: SCL rises entering Q2, falls entering Q0
      if (tick && state_q != IDLE && state_q != START && state_q != STOP) begin
        if (phase == 2'd1) scl_q <= 1'b1;
        if (phase == 2'd3) scl_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q      <= cmd_addr;
            rw_q        <= cmd_rw;
            cnt_q       <= cmd_len;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            nack_q      <= 1'b0;
            sda_q       <= 1'b0;
            scl_q       <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          if (tick && phase == 2'd1) scl_q <= 1'b0;
          if (tick && phase == 2'd3) begin
            sh_q    <= {addr_q, rw_q};
            sda_q   <= addr_q[6];
            bit_q   <= 3'd7;
            state_q <= ADDR;
          end
        end
        ADDR, WDATA: begin
          if (stall_q) begin
            if (wr_valid) begin
              sh_q       <= wr_data;
              sda_q      <= wr_data[7];
              wr_ready_q <= 1'b1;
              stall_q    <= 1'b0;
            end
          end else if (tick && phase == 2'd3) begin
            if (bit_q == 3'd0) begin
              sda_q   <= 1'b1;
              state_q <= (state_q == ADDR) ? ADDR_ACK : WACK;
            end else begin
              sh_q  <= {sh_q[6:0], 1'b0};
              sda_q <= sh_q[6];
              bit_q <= bit_q - 3'd1;
            end
          end
        end
        ADDR_ACK, WACK: begin
          if (tick && phase == 2'd2) ack_q <= sda_in;
          if (tick && phase == 2'd3) begin
            if (state_q == WACK) cnt_q <= cnt_d;
            if (ack_q == NACK) begin
              nack_q  <= 1'b1;
              sda_q   <= 1'b0;
              state_q <= STOP;
            end else if ((state_q == ADDR_ACK && cnt_q == '0) ||
                         (state_q == WACK && cnt_d == '0)) begin
              sda_q   <= 1'b0;
              state_q <= STOP;
            end else if (state_q == ADDR_ACK && rw_q == I2C_READ) begin
              sda_q   <= 1'b1;
              bit_q   <= 3'd7;
              state_q <= RDATA;
            end else begin
              bit_q   <= 3'd7;
              state_q <= WDATA;
              if (wr_valid) begin
                sh_q       <= wr_data;
                sda_q      <= wr_data[7];
                wr_ready_q <= 1'b1;
              end else begin
                stall_q <= 1'b1;
              end
            end
          end
        end
        RDATA: begin
          if (tick && phase == 2'd2) begin
            sh_q <= sh_rx_d;
            if (bit_q == 3'd0) begin
              rd_data_q  <= sh_rx_d;
              rd_valid_q <= 1'b1;
            end
          end
          if (tick && phase == 2'd3) begin
            if (bit_q == 3'd0) begin
              cnt_q   <= cnt_d;
              sda_q   <= (cnt_d != '0) ? ACK : NACK;
              state_q <= RACK;
            end else begin
              bit_q <= bit_q - 3'd1;
            end
          end
        end
        RACK: begin
          if (tick && phase == 2'd3) begin
            if (cnt_q != '0) begin
              sda_q   <= 1'b1;
              bit_q   <= 3'd7;
              state_q <= RDATA;
            end else begin
              sda_q   <= 1'b0;
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (tick && phase == 2'd0) scl_q <= 1'b1;
          if (tick && phase == 2'd2) sda_q <= 1'b1;
          if (tick && phase == 2'd3) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack_err  = nack_q;
  assign scl_out   = scl_q;
  assign sda_out   = sda_q;

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: open-drain slave model, bus decoder and scoreboards.
module tb_i2c_burst_master;

  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 4;
  localparam int EV_START = 1 << 12;
  localparam int EV_STOP  = 2 << 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       wr_data, rd_data;
  logic             wr_valid, wr_ready, rd_valid;
  logic             busy, done, nack_err, scl_out, sda_out;
  logic             slave_sda;
  wire              sda_line = sda_out & slave_sda;

  int n_chk = 0;
  int n_fail = 0;
  int bus_exp[$];
  int rd_exp[$];
  logic [7:0] rd_src[$];
  logic [7:0] wr_src[$];
  int  wr_cnt;
  int  nack_at;
  bit  ack_addr;

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .nack_err(nack_err), .scl_out(scl_out), .sda_out(sda_out), .sda_in(sda_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ev_byte(input logic [7:0] b, input logic ack);
    return (3 << 12) | (int'(ack) << 8) | int'(b);
  endfunction

  function automatic int pop_bus();
    if (bus_exp.size() == 0) return -1;
    return bus_exp.pop_front();
  endfunction

  // bus decoder plus slave: slave updates SDA one clk after SCL falls
  logic       pscl, psda, sl_active, sl_read, last_mack;
  int         mcnt, byte_idx;
  logic [7:0] msh, sl_cur;

  always @(posedge clk) begin
    if (rst) begin
      pscl <= 1'b1; psda <= 1'b1; slave_sda <= 1'b1;
      mcnt <= 0; byte_idx <= 0; sl_active <= 1'b0; sl_read <= 1'b0;
      last_mack <= 1'b1; msh <= 8'd0; sl_cur <= 8'd0;
    end else begin
      pscl <= scl_out;
      psda <= sda_line;
      if (pscl && scl_out && psda && !sda_line) begin
        check("bus_start", EV_START, pop_bus());
        mcnt <= 0; byte_idx <= 0; sl_active <= 1'b0;
      end else if (pscl && scl_out && !psda && sda_line) begin
        check("bus_stop", EV_STOP, pop_bus());
        mcnt <= 0; sl_active <= 1'b0;
      end else if (!pscl && scl_out) begin
        if (mcnt == 8) begin
          check("bus_byte", ev_byte(msh, sda_line), pop_bus());
          mcnt <= 0;
          byte_idx <= byte_idx + 1;
          last_mack <= sda_line;
          if (byte_idx == 0) begin
            sl_active <= ack_addr;
            sl_read   <= msh[0];
          end
        end else begin
          msh  <= {msh[6:0], sda_line};
          mcnt <= mcnt + 1;
        end
      end else if (pscl && !scl_out) begin
        if (mcnt == 8) begin
          if (byte_idx == 0)                slave_sda <= ack_addr ? 1'b0 : 1'b1;
          else if (sl_active && !sl_read)   slave_sda <= (byte_idx == nack_at) ? 1'b1 : 1'b0;
          else                              slave_sda <= 1'b1;
        end else if (mcnt == 0) begin
          if (sl_active && sl_read && (byte_idx == 1 || !last_mack) && rd_src.size() > 0) begin
            slave_sda <= rd_src[0][7];
            sl_cur    <= rd_src.pop_front();
          end else begin
            slave_sda <= 1'b1;
          end
        end else begin
          slave_sda <= (sl_active && sl_read && byte_idx >= 1) ? sl_cur[7 - mcnt] : 1'b1;
        end
      end
    end
  end

  // write-data source and read-data scoreboard
  initial begin
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_ready) begin
        if (wr_src.size() > 0) void'(wr_src.pop_front());
        wr_cnt++;
      end
      wr_valid = (wr_src.size() > 0);
      wr_data  = wr_valid ? wr_src[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) check("rd_data", int'(rd_data), (rd_exp.size() > 0) ? rd_exp.pop_front() : -1);
    end
  end

  task automatic run_cmd(input logic [6:0] a, input logic rw, input int len,
                         input bit poke, output int dur);
    @(negedge clk);
    cmd_addr = a; cmd_rw = rw; cmd_len = LEN_W'(len); cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    dur = 0;
    while (!done && dur < 5000) begin
      @(negedge clk);
      dur++;
      if (poke && dur == 20) begin
        check("cmd_ready_while_busy", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_addr = 7'h11; cmd_rw = 1'b1;
      end
      if (poke && dur == 40) cmd_valid = 1'b0;
    end
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  int dur, highs, exp_cyc;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 7'd0; cmd_rw = 1'b0; cmd_len = '0;
    wr_cnt = 0; nack_at = 0; ack_addr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl", scl_out, 1);
    check("rst_sda", sda_out, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack_err, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // write 0x50, two bytes, all ACKed; a command offered mid-transfer is ignored
    wr_cnt = 0;
    wr_src.push_back(8'hA5); wr_src.push_back(8'h3C);
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'hA0, 1'b0));
    bus_exp.push_back(ev_byte(8'hA5, 1'b0));
    bus_exp.push_back(ev_byte(8'h3C, 1'b0));
    bus_exp.push_back(EV_STOP);
    run_cmd(7'h50, 1'b0, 2, 1'b1, dur);
    exp_cyc = (2 + 9 * 3) * 4 * CLK_DIV;
    check("write_duration", int'(dur >= exp_cyc - 4 * CLK_DIV && dur <= exp_cyc + 4 * CLK_DIV), 1);
    check("write_wr_ready", wr_cnt, 2);
    check("write_nack", nack_err, 0);
    repeat (20) @(negedge clk);
    check("ignored_cmd_idle", busy, 0);

    // read 0x68, three bytes: master ACK, ACK, NACK
    rd_src.push_back(8'h11); rd_src.push_back(8'h22); rd_src.push_back(8'h33);
    rd_exp.push_back(8'h11); rd_exp.push_back(8'h22); rd_exp.push_back(8'h33);
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'hD1, 1'b0));
    bus_exp.push_back(ev_byte(8'h11, 1'b0));
    bus_exp.push_back(ev_byte(8'h22, 1'b0));
    bus_exp.push_back(ev_byte(8'h33, 1'b1));
    bus_exp.push_back(EV_STOP);
    run_cmd(7'h68, 1'b1, 3, 1'b0, dur);
    check("read_nack", nack_err, 0);
    check("read_last_data", rd_data, 8'h33);

    // address NACK: no data phase
    wr_cnt = 0; ack_addr = 1'b0;
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'hFE, 1'b1));
    bus_exp.push_back(EV_STOP);
    run_cmd(7'h7F, 1'b0, 2, 1'b0, dur);
    check("addr_nack_err", nack_err, 1);
    check("addr_nack_wr_ready", wr_cnt, 0);
    ack_addr = 1'b1;

    // write three bytes, slave NACKs the first data byte
    wr_cnt = 0; nack_at = 1;
    wr_src.push_back(8'hC3); wr_src.push_back(8'h5A); wr_src.push_back(8'h0F);
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'h58, 1'b0));
    bus_exp.push_back(ev_byte(8'hC3, 1'b1));
    bus_exp.push_back(EV_STOP);
    run_cmd(7'h2C, 1'b0, 3, 1'b0, dur);
    check("data_nack_err", nack_err, 1);
    check("data_nack_wr_ready", wr_cnt, 1);
    nack_at = 0;
    repeat (2) @(negedge clk);
    wr_src.delete();

    // write data withheld for 100 cycles: SCL must stay low
    wr_cnt = 0;
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'h74, 1'b0));
    bus_exp.push_back(ev_byte(8'h96, 1'b0));
    bus_exp.push_back(EV_STOP);
    fork
      run_cmd(7'h3A, 1'b0, 1, 1'b0, dur);
      begin
        repeat (90) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (scl_out) highs++;
        end
        check("stall_scl_low", highs, 0);
        check("stall_no_wr_ready", wr_cnt, 0);
        wr_src.push_back(8'h96);
      end
    join
    check("stall_wr_ready", wr_cnt, 1);
    check("stall_nack", nack_err, 0);

    // reset mid-RDATA, then a clean address probe
    rd_src.push_back(8'h00); rd_src.push_back(8'h00);
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'hD1, 1'b0));
    @(negedge clk);
    cmd_addr = 7'h68; cmd_rw = 1'b1; cmd_len = LEN_W'(2); cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_scl", scl_out, 1);
    check("abort_sda", sda_out, 1);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_rd_data", rd_data, 0);
    check("abort_queue_drained", bus_exp.size(), 0);
    rst = 1'b0;
    rd_src.delete(); rd_exp.delete();
    repeat (5) @(negedge clk);
    bus_exp.push_back(EV_START);
    bus_exp.push_back(ev_byte(8'h40, 1'b0));
    bus_exp.push_back(EV_STOP);
    run_cmd(7'h20, 1'b0, 0, 1'b0, dur);
    check("probe_nack", nack_err, 0);

    repeat (10) @(negedge clk);
    check("bus_queue_empty", bus_exp.size(), 0);
    check("rd_queue_empty", rd_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
